// File: rtl/host_sequencer.sv
// ============================================================================
// Module      : host_sequencer
// Description : Loads a job into data memory, kicks the processor, times the
//               run, then streams the result bytes back out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module host_sequencer #(
    parameter int LOAD_BYTES   = 64,
    parameter int RESULT_BASE  = 64,
    parameter int RESULT_BYTES = 32,
    parameter int TIMEOUT      = 4096
) (
    input  logic        clock,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        dm_we,
    output logic [7:0]  dm_addr,
    output logic [7:0]  dm_wdata,
    input  logic [7:0]  dm_rdata,
    output logic        cpu_start,
    input  logic        cpu_done,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] run_cycles
);

    localparam logic [2:0]  c_ST_LOAD = 3'd0;
    localparam logic [2:0]  c_ST_KICK = 3'd1;
    localparam logic [2:0]  c_ST_RUN  = 3'd2;
    localparam logic [2:0]  c_ST_READ = 3'd3;
    localparam logic [2:0]  c_ST_ERR  = 3'd4;

    localparam logic [7:0]  c_LOAD_LAST   = 8'(LOAD_BYTES - 1);
    localparam logic [7:0]  c_READ_LAST   = 8'(RESULT_BYTES - 1);
    localparam logic [7:0]  c_RESULT_BASE = 8'(RESULT_BASE);
    localparam logic [15:0] c_TIMEOUT_END = 16'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_nextState;
    logic [7:0]  r_loadCnt;
    logic [7:0]  r_rdCnt;
    logic [15:0] r_cycCnt;
    logic [15:0] r_runCycles;
    logic        w_inReady;
    logic        w_dmWe;
    logic [7:0]  w_dmAddr;
    logic [7:0]  w_dmWdata;
    logic        w_cpuStart;
    logic        w_outValid;
    logic        w_busy;

    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            r_state <= c_ST_LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // in_ready is gated by start so nothing handshakes while reset is held
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_dmWe      = 1'b0;
        w_dmAddr    = 8'd0;
        w_dmWdata   = 8'd0;
        w_cpuStart  = 1'b0;
        w_outValid  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_ST_LOAD: begin
                w_inReady = ~start;
                if (in_valid && w_inReady) begin
                    w_dmWe    = 1'b1;
                    w_dmAddr  = r_loadCnt;
                    w_dmWdata = in_data;
                    if (r_loadCnt == c_LOAD_LAST) begin
                        w_nextState = c_ST_KICK;
                    end
                end
            end
            c_ST_KICK: begin
                w_cpuStart  = 1'b1;
                w_busy      = 1'b1;
                w_nextState = c_ST_RUN;
            end
            c_ST_RUN: begin
                w_busy = 1'b1;
                if (cpu_done) begin
                    w_nextState = c_ST_READ;
                end else if (r_cycCnt == c_TIMEOUT_END) begin
                    w_nextState = c_ST_ERR;
                end
            end
            c_ST_READ: begin
                w_outValid = 1'b1;
                w_dmAddr   = c_RESULT_BASE + r_rdCnt;
                if (out_ready && (r_rdCnt == c_READ_LAST)) begin
                    w_nextState = c_ST_LOAD;
                end
            end
            c_ST_ERR: begin
                w_nextState = c_ST_ERR;
            end
            default: begin
                w_nextState = c_ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            r_loadCnt   <= 8'd0;
            r_rdCnt     <= 8'd0;
            r_cycCnt    <= 16'd0;
            r_runCycles <= 16'd0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (w_dmWe) begin
                        r_loadCnt <= (r_loadCnt == c_LOAD_LAST) ? 8'd0 : r_loadCnt + 8'd1;
                    end
                end
                c_ST_KICK: begin
                    r_cycCnt <= 16'd0;
                end
                c_ST_RUN: begin
                    if (r_cycCnt != 16'hFFFF) begin
                        r_cycCnt <= r_cycCnt + 16'd1;
                    end
                    if (cpu_done) begin
                        r_runCycles <= r_cycCnt;
                    end
                end
                c_ST_READ: begin
                    if (out_ready) begin
                        if (r_rdCnt == c_READ_LAST) begin
                            r_rdCnt   <= 8'd0;
                            r_loadCnt <= 8'd0;
                        end else begin
                            r_rdCnt <= r_rdCnt + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = w_inReady;
    assign dm_we       = w_dmWe;
    assign dm_addr     = w_dmAddr;
    assign dm_wdata    = w_dmWdata;
    assign cpu_start   = w_cpuStart;
    assign out_valid   = w_outValid;
    // Address is held during a stall, so the read data is held too
    assign out_data    = w_outValid ? dm_rdata : 8'd0;
    assign busy        = w_busy;
    assign timeout_err = (r_state == c_ST_ERR);
    assign run_cycles  = r_runCycles;

endmodule

`default_nettype wire

// File: tb/tb_host_sequencer.sv
// ============================================================================
// Module      : tb_host_sequencer
// Description : Directed scoreboard bench for host_sequencer (TIMEOUT=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_host_sequencer;

    logic        clock;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_wdata;
    logic [7:0]  dm_rdata;
    logic        cpu_start;
    logic        cpu_done;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic        timeout_err;
    logic [15:0] run_cycles;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wrQ[$];
    logic [7:0] rdQ[$];
    logic [7:0] mem [256];
    int         nPass;
    int         nChecks;

    host_sequencer #(
        .LOAD_BYTES  (64),
        .RESULT_BASE (64),
        .RESULT_BYTES(32),
        .TIMEOUT     (16)
    ) dut (
        .clock      (clock),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .cpu_start  (cpu_start),
        .cpu_done   (cpu_done),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .timeout_err(timeout_err),
        .run_cycles (run_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] resPat(input int i);
        return 8'(8'h5A + i * 7);
    endfunction

    // Result window 64..95 behaves as processor-written results
    always @(posedge clock) if (dm_we) mem[dm_addr] <= dm_wdata;
    assign dm_rdata = (dm_addr >= 8'd64 && dm_addr < 8'd96) ? resPat(int'(dm_addr) - 64)
                                                             : mem[dm_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic loadBytes(input int n, input bit gapped, input logic [7:0] seed);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            if (gapped) begin
                @(negedge clock);
                in_valid = 1'b0;
                #1;
                check("gap_we", 32'(dm_we), 32'd0);
            end
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = seed ^ 8'(i);
            wrQ.push_back('{addr: 8'(i), data: seed ^ 8'(i)});
            #1;
            check("load_ready", 32'(in_ready), 32'd1);
            check("load_we", 32'(dm_we), 32'd1);
            if (dm_we && wrQ.size() > 0) begin
                e = wrQ.pop_front();
                check("load_addr", 32'(dm_addr), 32'(e.addr));
                check("load_wdata", 32'(dm_wdata), 32'(e.data));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        int stallCnt;
        logic [7:0] e;
        nPass     = 0;
        nChecks   = 0;
        start     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        cpu_done  = 1'b0;
        out_ready = 1'b0;

        // Reset state while start is held
        @(negedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_dm_we", 32'(dm_we), 32'd0);
        check("rst_cpu_start", 32'(cpu_start), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_run_cycles", 32'(run_cycles), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        start = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_dm_addr", 32'(dm_addr), 32'd0);

        // Job 1: 0x00..0x3F back to back
        loadBytes(64, 1'b0, 8'h00);
        @(negedge clock);
        cpu_done = 1'b1;           // ignored in KICK
        #1;
        check("kick_cpu_start", 32'(cpu_start), 32'd1);
        check("kick_busy", 32'(busy), 32'd1);
        check("kick_we", 32'(dm_we), 32'd0);
        check("kick_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clock);
            cpu_done = (j == 10);
            #1;
            check("run_busy", 32'(busy), 32'd1);
            check("run_cpu_start", 32'(cpu_start), 32'd0);
        end

        // Read back with a 5-cycle stall at byte 10
        for (int i = 0; i < 32; i++) rdQ.push_back(resPat(i));
        idx = 0;
        cyc = 0;
        stallCnt = 0;
        while (idx < 32 && cyc < 200) begin
            cyc++;
            @(negedge clock);
            cpu_done = 1'b0;
            if (idx == 10 && stallCnt < 5) begin
                out_ready = 1'b0;
                stallCnt++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (cyc == 1) check("run_cycles", 32'(run_cycles), 32'd9);
            check("rd_valid", 32'(out_valid), 32'd1);
            check("rd_addr", 32'(dm_addr), 32'(64 + idx));
            if (!out_ready && rdQ.size() > 0) begin
                check("stall_data", 32'(out_data), 32'(rdQ[0]));
            end else if (rdQ.size() > 0) begin
                e = rdQ.pop_front();
                check("rd_data", 32'(out_data), 32'(e));
                idx++;
            end
        end
        check("rd_count", 32'(idx), 32'd32);
        check("rd_stalls", 32'(stallCnt), 32'd5);
        @(negedge clock);
        out_ready = 1'b0;
        #1;
        check("post_rd_in_ready", 32'(in_ready), 32'd1);
        check("post_rd_out_valid", 32'(out_valid), 32'd0);
        check("post_rd_busy", 32'(busy), 32'd0);

        // Job 2: gapped load restarting at 0, then timeout
        loadBytes(64, 1'b1, 8'hC0);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("kick2_cpu_start", 32'(cpu_start), 32'd1);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clock);
            #1;
            check("run2_busy", 32'(busy), 32'd1);
            check("run2_timeout", 32'(timeout_err), 32'd0);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            in_valid  = 1'b1;
            cpu_done  = 1'b1;
            out_ready = 1'b1;
            #1;
            check("err_timeout", 32'(timeout_err), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
            check("err_in_ready", 32'(in_ready), 32'd0);
            check("err_out_valid", 32'(out_valid), 32'd0);
            check("err_we", 32'(dm_we), 32'd0);
            check("err_run_cycles", 32'(run_cycles), 32'd9);
        end
        @(negedge clock);
        in_valid  = 1'b0;
        cpu_done  = 1'b0;
        out_ready = 1'b0;
        start     = 1'b1;
        #1;
        check("errrst_timeout", 32'(timeout_err), 32'd0);
        check("errrst_run_cycles", 32'(run_cycles), 32'd0);
        @(negedge clock);
        start = 1'b0;
        #1;
        check("errrst_in_ready", 32'(in_ready), 32'd1);

        // Job 3: abort during RUN
        loadBytes(64, 1'b0, 8'h33);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("kick3_cpu_start", 32'(cpu_start), 32'd1);
        for (int j = 0; j < 3; j++) @(negedge clock);
        #1;
        check("run3_busy", 32'(busy), 32'd1);
        @(negedge clock);
        start = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cpu_start", 32'(cpu_start), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_dm_addr", 32'(dm_addr), 32'd0);
        @(negedge clock);
        start = 1'b0;

        // Abort mid-LOAD, restart at address 0
        loadBytes(3, 1'b0, 8'h11);
        @(negedge clock);
        start = 1'b1;
        #1;
        check("ldabort_we", 32'(dm_we), 32'd0);
        check("ldabort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        start    = 1'b0;
        in_valid = 1'b0;
        loadBytes(2, 1'b0, 8'h22);
        @(negedge clock);
        in_valid = 1'b0;
        check("wrq_empty", 32'(wrQ.size()), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/host_sequencer.md
HOST_SEQUENCER -- requirements
Module: host_sequencer

Interface
REQ-001 The block SHALL have parameter LOAD_BYTES, default 64, giving the number of bytes loaded into data memory per job (1..256).
REQ-002 The block SHALL have parameter RESULT_BASE, default 64, giving the first data-memory address read back after a run.
REQ-003 The block SHALL have parameter RESULT_BYTES, default 32, giving the number of result bytes read back; RESULT_BASE+RESULT_BYTES SHALL be <= 256.
REQ-004 The block SHALL have parameter TIMEOUT, default 4096, giving the maximum number of cycles spent waiting for cpu_done.
REQ-005 Port: clock  in  1  single clock; all state rises on posedge clock.
REQ-006 Port: start  in  1  reset, asynchronous, active-high.
REQ-007 Port: in_valid  in  1; in_data  in  8; in_ready  out  1  load-byte stream, valid/ready.
REQ-008 Port: dm_we  out  1; dm_addr  out  8; dm_wdata  out  8  data-memory write/read port.
REQ-009 Port: dm_rdata  in  8  data-memory read data, combinational from dm_addr.
REQ-010 Port: cpu_start  out  1  processor start pulse.
REQ-011 Port: cpu_done  in  1  processor completion.
REQ-012 Port: out_valid  out  1; out_data  out  8; out_ready  in  1  result stream, valid/ready.
REQ-013 Port: busy  out  1  high in KICK and RUN.
REQ-014 Port: timeout_err  out  1  sticky timeout flag.
REQ-015 Port: run_cycles  out  16  cycle count of the last run.

Function
REQ-016 The state machine SHALL have states LOAD, KICK, RUN, READ and ERR.
REQ-017 In LOAD, in_ready SHALL be 1.
REQ-018 In LOAD, each in_valid&in_ready cycle SHALL drive dm_we=1, dm_addr=load_cnt and dm_wdata=in_data in that same cycle, then increment load_cnt.
REQ-019 When the accepted byte is number LOAD_BYTES (load_cnt = LOAD_BYTES-1), the next state SHALL be KICK.
REQ-020 dm_we SHALL be 0 in every state other than LOAD and in every cycle without a handshake.
REQ-021 KICK SHALL last exactly 1 cycle with cpu_start=1.
REQ-022 cpu_start SHALL be 0 in all other states.
REQ-023 On leaving KICK, the cycle counter SHALL clear to 0 and the state SHALL become RUN.
REQ-024 In RUN, the cycle counter SHALL increment every cycle, saturating at 16'hFFFF.
REQ-025 In RUN, cpu_done=1 SHALL latch the counter value into run_cycles and move to READ on the next edge.
REQ-026 In RUN, if the counter reaches TIMEOUT-1 with cpu_done=0, the state SHALL move to ERR.
REQ-027 cpu_done SHALL be ignored in LOAD, KICK and READ.
REQ-028 In READ, dm_addr SHALL equal RESULT_BASE+rd_cnt (8-bit), out_valid SHALL be 1 and out_data SHALL equal dm_rdata.
REQ-029 In READ, out_valid&out_ready SHALL increment rd_cnt.
REQ-030 Out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-031 After byte number RESULT_BYTES is accepted, load_cnt and rd_cnt SHALL clear and the state SHALL return to LOAD for the next job.
REQ-032 out_valid SHALL be 0 outside READ, and in_ready SHALL be 0 outside LOAD.
REQ-033 In ERR, timeout_err SHALL be 1 and the block SHALL stay in ERR until reset; all handshake outputs SHALL be 0.
REQ-034 run_cycles SHALL hold its value until the next cpu_done latch or reset.
REQ-035 When dm_addr is not driven by a state, it SHALL be 0.

Reset
REQ-036 start=1 SHALL asynchronously force: state LOAD, load_cnt=0, rd_cnt=0, cycle counter=0, run_cycles=0, timeout_err=0, cpu_start=0, dm_we=0, out_valid=0, in_ready=0 while start is high.
REQ-037 An assertion of start mid-LOAD, RUN or READ SHALL abort the job; after release, loading SHALL restart at address 0.

Verification
REQ-038 Load bytes 0x00..0x3F with in_valid held high -> 64 consecutive writes to addresses 0..63, then a 1-cycle cpu_start pulse, then busy=1.
REQ-039 Stall the input by gapping in_valid every other cycle -> no dm_we in gap cycles and addresses contiguous with no skips.
REQ-040 Assert cpu_done 10 cycles after cpu_start -> run_cycles=10 (±1 as defined by REQ-024/025), then out_data equals memory[64..95] in order.
REQ-041 Hold out_ready=0 for 5 cycles mid-read -> out_data and dm_addr are unchanged and no byte is lost or duplicated.
REQ-042 Use TIMEOUT=16 with cpu_done never asserted -> ERR with timeout_err=1, which persists until start; after start, timeout_err=0 and in_ready=1.
REQ-043 Pulse start during RUN -> all outputs reach their reset values immediately, and the next load begins at dm_addr=0.
